// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the two-entry pipeline stage buffer: default widths,
// the bubble instruction and the packed shape of one held stage entry.
package pipe_stage_buf_pkg;

    localparam int PSB_DATA_W = 16;
    localparam int PSB_PC_W   = 16;

    // Instruction presented downstream whenever no entry is valid.
    localparam logic [PSB_DATA_W-1:0] PSB_NOP_INSTR = 16'h0000;

    // One held stage entry at the default widths.
    typedef struct packed {
        logic                  valid;
        logic [PSB_DATA_W-1:0] instr;
        logic [PSB_PC_W-1:0]   pc;
        logic [PSB_PC_W-1:0]   next_pc;
    } stage_entry_t;

    // Number of held entries from the two valid bits.
    function automatic logic [1:0] occ_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One stage-entry register: valid bit plus instruction and PC fields.
// Reset and clear both zero the whole entry so no stale data survives;
// clear wins over load so a kill always empties the slot.
module pipe_entry_reg
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W = PSB_DATA_W,
    parameter int PC_W   = PSB_PC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [PC_W-1:0]   i_next_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [PC_W-1:0]   o_pc,
    output logic [PC_W-1:0]   o_next_pc
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_next_pc;

    // Entry state: reset > clear > load > hold.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_pc      <= '0;
            r_next_pc <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_instr   <= i_instr;
            r_pc      <= i_pc;
            r_next_pc <= i_next_pc;
        end
    end

    assign o_valid   = r_valid;
    assign o_instr   = r_instr;
    assign o_pc      = r_pc;
    assign o_next_pc = r_next_pc;

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (main + skid). Main drives the outputs;
// skid catches the one entry that can arrive while main is stalled. in_ready
// is a flop, so upstream never sees a combinational path from out_ready.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                DATA_W    = PSB_DATA_W,
    parameter int                PC_W      = PSB_PC_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(PSB_NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_next_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_next_pc,
    output logic [1:0]        occ
);

    // Slot 0 is main, slot 1 is skid.
    localparam int MAIN = 0;
    localparam int SKID = 1;

    logic              w_load     [2];
    logic              w_clear    [2];
    logic [DATA_W-1:0] w_d_instr  [2];
    logic [PC_W-1:0]   w_d_pc     [2];
    logic [PC_W-1:0]   w_d_npc    [2];
    logic              w_q_valid  [2];
    logic [DATA_W-1:0] w_q_instr  [2];
    logic [PC_W-1:0]   w_q_pc     [2];
    logic [PC_W-1:0]   w_q_npc    [2];

    logic       r_in_ready;
    logic [1:0] r_occ;

    logic w_in_xfer;
    logic w_main_leave;
    logic w_main_from_skid;
    logic w_main_from_in;
    logic w_skid_from_in;
    logic w_main_valid_next;
    logic w_skid_valid_next;

    assign w_in_xfer    = in_valid & r_in_ready;
    assign w_main_leave = w_q_valid[MAIN] & out_ready;

    // Main refills from skid first (oldest entry), else from the input when
    // it is empty or being vacated with nothing waiting behind it.
    assign w_main_from_skid = w_main_leave & w_q_valid[SKID];
    assign w_main_from_in   = w_in_xfer &
                              (~w_q_valid[MAIN] | (w_main_leave & ~w_q_valid[SKID]));
    // Input goes to skid whenever main stays (or is refilled from skid).
    assign w_skid_from_in   = w_in_xfer & w_q_valid[MAIN] &
                              (~w_main_leave | w_q_valid[SKID]);

    assign w_main_valid_next = w_main_from_skid | w_main_from_in |
                               (w_q_valid[MAIN] & ~w_main_leave);
    assign w_skid_valid_next = w_skid_from_in | (w_q_valid[SKID] & ~w_main_leave);

    // Slot controls; a slot is cleared whenever it will hold nothing.
    assign w_load[MAIN]    = w_main_from_skid | w_main_from_in;
    assign w_clear[MAIN]   = flush | ~w_main_valid_next;
    assign w_d_instr[MAIN] = w_main_from_skid ? w_q_instr[SKID] : in_instr;
    assign w_d_pc[MAIN]    = w_main_from_skid ? w_q_pc[SKID]    : in_pc;
    assign w_d_npc[MAIN]   = w_main_from_skid ? w_q_npc[SKID]   : in_next_pc;

    assign w_load[SKID]    = w_skid_from_in;
    assign w_clear[SKID]   = flush | ~w_skid_valid_next;
    assign w_d_instr[SKID] = in_instr;
    assign w_d_pc[SKID]    = in_pc;
    assign w_d_npc[SKID]   = in_next_pc;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            pipe_entry_reg #(
                .DATA_W (DATA_W),
                .PC_W   (PC_W)
            ) u_entry (
                .clk       (clk),
                .rst       (rst),
                .i_load    (w_load[gi]),
                .i_clear   (w_clear[gi]),
                .i_instr   (w_d_instr[gi]),
                .i_pc      (w_d_pc[gi]),
                .i_next_pc (w_d_npc[gi]),
                .o_valid   (w_q_valid[gi]),
                .o_instr   (w_q_instr[gi]),
                .o_pc      (w_q_pc[gi]),
                .o_next_pc (w_q_npc[gi])
            );
        end
    endgenerate

    // Registered handshake and occupancy, tracking the slots' next state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_in_ready <= 1'b1;
            r_occ      <= 2'd0;
        end else begin
            r_in_ready <= ~w_skid_valid_next;
            r_occ      <= occ_count(w_main_valid_next, w_skid_valid_next);
        end
    end

    assign in_ready    = r_in_ready;
    assign occ         = r_occ;
    assign out_valid   = w_q_valid[MAIN];
    assign out_instr   = w_q_valid[MAIN] ? w_q_instr[MAIN] : NOP_INSTR;
    assign out_pc      = w_q_valid[MAIN] ? w_q_pc[MAIN]    : '0;
    assign out_next_pc = w_q_valid[MAIN] ? w_q_npc[MAIN]   : '0;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios on a default-width instance,
// then randomised traffic on a 32-bit instance checked against a queue model.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Default-width instance (directed).
    logic        a_rst = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [15:0] a_in_instr = '0, a_in_pc = '0, a_in_npc = '0;
    logic        a_in_ready, a_out_valid;
    logic [15:0] a_out_instr, a_out_pc, a_out_npc;
    logic [1:0]  a_occ;

    pipe_stage_buf u_dut16 (
        .clk         (clk),
        .rst         (a_rst),
        .flush       (a_flush),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_instr    (a_in_instr),
        .in_pc       (a_in_pc),
        .in_next_pc  (a_in_npc),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_instr   (a_out_instr),
        .out_pc      (a_out_pc),
        .out_next_pc (a_out_npc),
        .occ         (a_occ)
    );

    // 32-bit instance (random), with a non-zero bubble so gating is visible.
    localparam logic [31:0] NOP32 = 32'h0000_0013;
    logic        b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [31:0] b_in_instr = '0, b_in_pc = '0, b_in_npc = '0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_instr, b_out_pc, b_out_npc;
    logic [1:0]  b_occ;

    pipe_stage_buf #(
        .DATA_W    (32),
        .PC_W      (32),
        .NOP_INSTR (NOP32)
    ) u_dut32 (
        .clk         (clk),
        .rst         (b_rst),
        .flush       (b_flush),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_instr    (b_in_instr),
        .in_pc       (b_in_pc),
        .in_next_pc  (b_in_npc),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_instr   (b_out_instr),
        .out_pc      (b_out_pc),
        .out_next_pc (b_out_npc),
        .occ         (b_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check every output of the default-width instance in one go.
    task automatic check_a(input string tag, input logic ov, input logic [15:0] oi,
                           input logic [15:0] op, input logic [15:0] onp,
                           input logic ir, input logic [1:0] oc);
        check({tag, ".out_valid"},   32'(a_out_valid), 32'(ov));
        check({tag, ".out_instr"},   32'(a_out_instr), 32'(oi));
        check({tag, ".out_pc"},      32'(a_out_pc),    32'(op));
        check({tag, ".out_next_pc"}, 32'(a_out_npc),   32'(onp));
        check({tag, ".in_ready"},    32'(a_in_ready),  32'(ir));
        check({tag, ".occ"},         32'(a_occ),       32'(oc));
        $display("step %-10s out_valid=%0d out_instr=%h out_pc=%h in_ready=%0d occ=%0d",
                 tag, a_out_valid, a_out_instr, a_out_pc, a_in_ready, a_occ);
    endtask

    task automatic present_a(input logic v, input logic [15:0] instr, input logic [15:0] pc);
        a_in_valid = v;
        a_in_instr = instr;
        a_in_pc    = pc;
        a_in_npc   = pc + 16'd2;
    endtask

    // Reference model: FIFO of up to two held entries.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
    } ent_t;
    ent_t model_q[$];

    localparam logic [15:0] A1 = 16'h1111, A2 = 16'h2222, A3 = 16'h3333, A4 = 16'h4444;

    initial begin
        int   n_acc;
        int   n_del;
        bit   acc;
        ent_t e;
        ent_t h;
        logic [15:0] stream [4];
        stream[0] = A1; stream[1] = A2; stream[2] = A3; stream[3] = A4;

        // ---- Reset for two cycles ----
        a_rst = 1'b1;
        tick();
        tick();
        check_a("reset", 1'b0, 16'h0000, 16'h0, 16'h0, 1'b1, 2'd0);
        a_rst = 1'b0;

        // ---- Stream A1..A4 with downstream always ready ----
        a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            present_a(1'b1, stream[k], 16'(2 * k));
            tick();
            check_a($sformatf("stream%0d", k), 1'b1, stream[k], 16'(2 * k),
                    16'(2 * k + 2), 1'b1, 2'd1);
        end
        present_a(1'b0, 16'h0, 16'h0);
        tick();
        check_a("drain", 1'b0, 16'h0000, 16'h0, 16'h0, 1'b1, 2'd0);

        // ---- Stall: A1,A2 accepted, A3 held upstream ----
        a_out_ready = 1'b0;
        present_a(1'b1, A1, 16'h0);
        tick();
        check_a("stall_a1", 1'b1, A1, 16'h0, 16'h2, 1'b1, 2'd1);
        present_a(1'b1, A2, 16'h2);
        tick();
        check_a("stall_a2", 1'b1, A1, 16'h0, 16'h2, 1'b0, 2'd2);
        present_a(1'b1, A3, 16'h4);
        tick();
        check_a("stall_a3", 1'b1, A1, 16'h0, 16'h2, 1'b0, 2'd2);
        a_out_ready = 1'b1;
        tick();
        check_a("resume_a2", 1'b1, A2, 16'h2, 16'h4, 1'b1, 2'd1);
        tick();
        check_a("resume_a3", 1'b1, A3, 16'h4, 16'h6, 1'b1, 2'd1);
        present_a(1'b0, 16'h0, 16'h0);
        tick();
        check_a("resume_end", 1'b0, 16'h0000, 16'h0, 16'h0, 1'b1, 2'd0);

        // ---- Flush with occ=2 and a same-cycle input ----
        a_out_ready = 1'b0;
        present_a(1'b1, A1, 16'h0);
        tick();
        present_a(1'b1, A2, 16'h2);
        tick();
        check_a("pre_flush", 1'b1, A1, 16'h0, 16'h2, 1'b0, 2'd2);
        a_out_ready = 1'b1;
        a_flush = 1'b1;
        present_a(1'b1, 16'h5555, 16'h8);
        tick();
        a_flush = 1'b0;
        present_a(1'b0, 16'h0, 16'h0);
        check_a("flush", 1'b0, 16'h0000, 16'h0, 16'h0, 1'b1, 2'd0);
        tick();
        check_a("post_flush", 1'b0, 16'h0000, 16'h0, 16'h0, 1'b1, 2'd0);

        // ---- Reset in the middle of a stall, then a fresh accept ----
        a_out_ready = 1'b0;
        present_a(1'b1, A3, 16'h4);
        tick();
        present_a(1'b1, A4, 16'h6);
        tick();
        check_a("pre_rst", 1'b1, A3, 16'h4, 16'h6, 1'b0, 2'd2);
        a_rst = 1'b1;
        present_a(1'b1, 16'h7777, 16'hA);
        tick();
        a_rst = 1'b0;
        present_a(1'b0, 16'h0, 16'h0);
        check_a("mid_rst", 1'b0, 16'h0000, 16'h0, 16'h0, 1'b1, 2'd0);
        present_a(1'b1, 16'hABCD, 16'h20);
        tick();
        present_a(1'b0, 16'h0, 16'h0);
        check_a("abcd", 1'b1, 16'hABCD, 16'h20, 16'h22, 1'b1, 2'd1);

        // ---- Randomised traffic on the 32-bit instance ----
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        model_q.delete();
        n_acc = 0;
        n_del = 0;
        for (int c = 0; c < 400; c++) begin
            b_in_valid  = ($urandom_range(0, 9) < 6);
            b_out_ready = ($urandom_range(0, 9) < 6);
            b_flush     = ($urandom_range(0, 39) == 0);
            b_rst       = ($urandom_range(0, 79) == 0);
            b_in_instr  = $urandom;
            b_in_pc     = $urandom;
            b_in_npc    = $urandom;

            // Model: accept when fewer than two held; head leaves on ready.
            acc = b_in_valid && (model_q.size() < 2);
            if (!b_rst && model_q.size() > 0 && b_out_ready) begin
                void'(model_q.pop_front());
                n_del++;
            end
            if (b_rst || b_flush) begin
                model_q.delete();
            end else if (acc) begin
                e.instr   = b_in_instr;
                e.pc      = b_in_pc;
                e.next_pc = b_in_npc;
                model_q.push_back(e);
                n_acc++;
            end

            tick();

            if (model_q.size() > 0) begin
                h = model_q[0];
                check("rnd.out_valid", 32'(b_out_valid), 32'd1);
                check("rnd.out_instr", b_out_instr, h.instr);
                check("rnd.out_pc", b_out_pc, h.pc);
                check("rnd.out_next_pc", b_out_npc, h.next_pc);
            end else begin
                check("rnd.out_valid", 32'(b_out_valid), 32'd0);
                check("rnd.out_instr", b_out_instr, NOP32);
                check("rnd.out_pc", b_out_pc, 32'd0);
                check("rnd.out_next_pc", b_out_npc, 32'd0);
            end
            check("rnd.in_ready", 32'(b_in_ready), 32'(model_q.size() < 2));
            check("rnd.occ", 32'(b_occ), 32'(model_q.size()));
            $display("cycle %0d rst=%0d flush=%0d in_v=%0d out_r=%0d out_valid=%0d out_instr=%h occ=%0d",
                     c, b_rst, b_flush, b_in_valid, b_out_ready, b_out_valid, b_out_instr, b_occ);
        end
        b_rst = 1'b0;
        b_flush = 1'b0;
        b_in_valid = 1'b0;
        $display("random traffic: %0d accepted, %0d delivered", n_acc, n_del);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL take parameter DATA_W, default 16, the instruction field width.
REQ-002 The block SHALL take parameter PC_W, default 16, the width of each PC field.
REQ-003 The block SHALL take parameter NOP_INSTR, default 16'h0000, the instruction value driven whenever out_valid=0.
REQ-004 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port flush, input, 1, kills all held entries and any same-cycle input.
REQ-007 Port in_valid, input, 1, upstream entry present.
REQ-008 Port in_ready, output, 1, block accepts an entry this cycle.
REQ-009 Port in_instr, input, DATA_W, instruction in.
REQ-010 Port in_pc, input, PC_W, PC of the instruction (old PC).
REQ-011 Port in_next_pc, input, PC_W, PC+2 or predicted target (new PC).
REQ-012 Port out_valid, output, 1, downstream entry present.
REQ-013 Port out_ready, input, 1, downstream accepts; low = stall.
REQ-014 Ports out_instr (DATA_W), out_pc (PC_W) and out_next_pc (PC_W), outputs, SHALL carry the head entry's fields.
REQ-015 Port occ, output, 2, number of held entries (0..2).

Function
REQ-016 Storage SHALL be 2 entries: main (drives outputs) and skid; each entry holds {valid, instr, pc, next_pc}.
REQ-017 in_ready SHALL be the registered value of !skid.valid, so it has no combinational path from out_ready.
REQ-018 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-019 Latency SHALL be 1 cycle: an entry accepted into an empty block appears on the outputs the next cycle.
REQ-020 With out_ready held high, throughput SHALL be 1 entry per cycle and occ SHALL never exceed 1.
REQ-021 When main is valid and not leaving, an input transfer SHALL load skid; skid full SHALL drive in_ready=0 next cycle.
REQ-022 When main leaves and skid is valid, skid SHALL move to main, and a simultaneous input transfer SHALL load skid.
REQ-023 Order SHALL be preserved: FIFO order, with no loss and no duplication.
REQ-024 With main empty and skid empty, input SHALL load main directly and SHALL never bypass combinationally to the outputs.
REQ-025 When out_valid=0, out_instr SHALL equal NOP_INSTR and out_pc/out_next_pc SHALL equal 0.
REQ-026 flush SHALL clear both valid bits at the next edge and discard any same-cycle input transfer; occ=0 and in_ready=1 next cycle.
REQ-027 Priority SHALL be rst > flush > normal transfer.
REQ-028 A same-cycle output transfer together with flush SHALL still be counted as consumed by the downstream stage.
REQ-029 occ SHALL equal main.valid + skid.valid, registered.

Reset
REQ-030 rst SHALL be sampled on the clk edge; at the next edge main.valid=0, skid.valid=0, in_ready=1, out_valid=0, occ=0, out_instr=NOP_INSTR, out_pc=0, out_next_pc=0.
REQ-031 rst mid-stall SHALL drop both held entries, and input presented in the rst cycle SHALL be discarded.
REQ-032 Data fields SHALL also be reset, so no X appears on outputs.

Structure
REQ-033 A shared package SHALL hold the default widths (DATA_W=16, PC_W=16), NOP_INSTR and a packed stage-entry struct {valid, instr, pc, next_pc}.
REQ-034 One sub-module, pipe_entry_reg, SHALL implement one entry register (load enable, clear, sync reset) and be instantiated twice.

Verification
REQ-035 rst for 2 cycles then release: out_valid=0, out_instr=16'h0000, in_ready=1, occ=0.
REQ-036 Stream A1..A4 (instr 16'h1111..16'h4444, pc 0,2,4,6) with out_ready=1: outputs A1..A4 on consecutive cycles, each 1 cycle after accept, occ=1 throughout.
REQ-037 out_ready=0 while sending A1,A2,A3: A1,A2 accepted, in_ready=0 after A2, occ=2, A3 held upstream; raising out_ready yields A1,A2,A3 in order, with no gaps after the first.
REQ-038 occ=2, then flush with in_valid=1 (instr 16'h5555): next cycle occ=0, out_valid=0, out_instr=NOP_INSTR, and 16'h5555 never appears.
REQ-039 Assert rst mid-stall with occ=2: next cycle all outputs are at reset values; a later accept of 16'hABCD appears after 1 cycle.
REQ-040 Randomised valid/ready with DATA_W=32, PC_W=32: the scoreboard SHALL match input order exactly and out_instr SHALL equal NOP_INSTR whenever out_valid=0.
